// File: rtl/regfile_sb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : regfile_pkg
// Description : Shared constants and helpers for the scoreboarded register
//               file: address-width function, default sizes, zero word.
// Revision    : 1.0 - initial release
// ============================================================================
package regfile_pkg;

  localparam int RF_DATA_WIDTH = 8;
  localparam int RF_NUM_REGS   = 8;

  localparam logic [RF_DATA_WIDTH-1:0] RF_ZERO_WORD = '0;

  // Address width for a given register count; never narrower than one bit.
  function automatic int addr_width(input int num_regs);
    return (num_regs <= 2) ? 1 : $clog2(num_regs);
  endfunction

endpackage
`default_nettype wire

// File: rtl/regfile_sb_if.sv
`default_nettype none
// ============================================================================
// Module      : regfile_sb_if
// Description : Write/reserve/read bus of the scoreboarded register file.
// Revision    : 1.0 - initial release
// ============================================================================
interface regfile_sb_if
  import regfile_pkg::*;
#(
  parameter int DATA_WIDTH = RF_DATA_WIDTH,
  parameter int NUM_REGS   = RF_NUM_REGS
);

  localparam int AW = addr_width(NUM_REGS);

  logic                  WRITEENABLE;
  logic [AW-1:0]         WRITEREG;
  logic [DATA_WIDTH-1:0] WRITEDATA;
  logic [AW-1:0]         READREG1;
  logic [AW-1:0]         READREG2;
  logic                  RESERVE;
  logic [AW-1:0]         RESERVEREG;
  logic [DATA_WIDTH-1:0] REGOUT1;
  logic [DATA_WIDTH-1:0] REGOUT2;
  logic                  BUSY1;
  logic                  BUSY2;

  modport master (
    output WRITEENABLE, WRITEREG, WRITEDATA, READREG1, READREG2,
    output RESERVE, RESERVEREG,
    input  REGOUT1, REGOUT2, BUSY1, BUSY2
  );

  modport slave (
    input  WRITEENABLE, WRITEREG, WRITEDATA, READREG1, READREG2,
    input  RESERVE, RESERVEREG,
    output REGOUT1, REGOUT2, BUSY1, BUSY2
  );

endinterface
`default_nettype wire

// File: rtl/reg_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : reg_scoreboard
// Description : Per-register busy bits. Set wins over clear on the same
//               register; out-of-range and (optionally) zero-register
//               addresses never set or report busy.
// Revision    : 1.0 - initial release
// ============================================================================
module reg_scoreboard
  import regfile_pkg::*;
#(
  parameter int NUM_REGS = RF_NUM_REGS,
  parameter bit ZERO_REG = 1'b0,
  localparam int AW      = addr_width(NUM_REGS)
) (
  input  logic          CLK,
  input  logic          RESET,
  input  logic          set_en,
  input  logic [AW-1:0] set_addr,
  input  logic          clr_en,
  input  logic [AW-1:0] clr_addr,
  input  logic [AW-1:0] query1_addr,
  input  logic [AW-1:0] query2_addr,
  output logic          busy1,
  output logic          busy2
);

  logic [NUM_REGS-1:0] busy;

  // Busy-bit update: a new reservation overrides a completing write.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      busy <= '0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (ZERO_REG && i == 0) begin
          busy[i] <= 1'b0;
        end else if (set_en && set_addr == AW'(i)) begin
          busy[i] <= 1'b1;
        end else if (clr_en && clr_addr == AW'(i)) begin
          busy[i] <= 1'b0;
        end
      end
    end
  end

  // Busy read-out; addresses beyond the array report not busy.
  always_comb begin
    busy1 = 1'b0;
    busy2 = 1'b0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (query1_addr == AW'(i)) busy1 = busy[i];
      if (query2_addr == AW'(i)) busy2 = busy[i];
    end
  end

endmodule
`default_nettype wire

// File: rtl/regfile_sb.sv
`default_nettype none
// ============================================================================
// Module      : regfile_sb
// Description : Parametrised register file, one synchronous write port, two
//               combinational read ports, optional write-to-read bypass,
//               optional hardwired zero register and a busy scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_sb
  import regfile_pkg::*;
#(
  parameter int DATA_WIDTH = RF_DATA_WIDTH,
  parameter int NUM_REGS   = RF_NUM_REGS,
  parameter bit BYPASS     = 1'b1,
  parameter bit ZERO_REG   = 1'b0
) (
  input  logic        CLK,
  input  logic        RESET,
  regfile_sb_if.slave bus
);

  localparam int AW = addr_width(NUM_REGS);

  logic [DATA_WIDTH-1:0] regs [NUM_REGS];
  logic                  wr_ok;
  logic                  byp1;
  logic                  byp2;
  logic [DATA_WIDTH-1:0] rd1;
  logic [DATA_WIDTH-1:0] rd2;

  // A write is effective only for an in-range, non-hardwired register.
  always_comb begin
    wr_ok = bus.WRITEENABLE && (int'(bus.WRITEREG) < NUM_REGS) &&
            !(ZERO_REG && bus.WRITEREG == '0);
  end

  // Storage: asynchronous clear, one write per edge.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (wr_ok && bus.WRITEREG == AW'(i)) regs[i] <= bus.WRITEDATA;
      end
    end
  end

  // Read muxes with range/zero masking and optional bypass of the write port.
  always_comb begin
    rd1 = '0;
    rd2 = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (!(ZERO_REG && i == 0)) begin
        if (bus.READREG1 == AW'(i)) rd1 = regs[i];
        if (bus.READREG2 == AW'(i)) rd2 = regs[i];
      end
    end
    // wr_ok already excludes out-of-range and zero-register targets.
    byp1 = BYPASS && wr_ok && (bus.WRITEREG == bus.READREG1);
    byp2 = BYPASS && wr_ok && (bus.WRITEREG == bus.READREG2);
  end

  // Outputs are forced to zero while reset is held, bypass included.
  assign bus.REGOUT1 = !RESET ? '0 : (byp1 ? bus.WRITEDATA : rd1);
  assign bus.REGOUT2 = !RESET ? '0 : (byp2 ? bus.WRITEDATA : rd2);

  reg_scoreboard #(
    .NUM_REGS (NUM_REGS),
    .ZERO_REG (ZERO_REG)
  ) u_scoreboard (
    .CLK         (CLK),
    .RESET       (RESET),
    .set_en      (bus.RESERVE),
    .set_addr    (bus.RESERVEREG),
    .clr_en      (bus.WRITEENABLE),
    .clr_addr    (bus.WRITEREG),
    .query1_addr (bus.READREG1),
    .query2_addr (bus.READREG2),
    .busy1       (bus.BUSY1),
    .busy2       (bus.BUSY2)
  );

endmodule
`default_nettype wire

// File: doc/regfile_sb.md
# regfile_sb

Parametrised register file with a busy-bit scoreboard, the successor to the 8×8 `regfile` in the datapath. It has one synchronous write port and two combinational read ports. It adds an optional write-to-read bypass and an optional hardwired zero register. A per-register busy scoreboard lets the control unit hold instructions whose source register awaits a multi-cycle result.

## Interface
- `DATA_WIDTH`, default 8: register width in bits.
- `NUM_REGS`, default 8: number of registers, minimum 2; need not be a power of two.
- `BYPASS`, default 1: if 1, a read of the register being written this cycle returns `WRITEDATA`.
- `ZERO_REG`, default 0: if 1, register 0 reads as 0 and ignores writes and reservations.
- `CLK` input, 1 bit: clock, rising-edge active.
- `RESET` input, 1 bit: reset is asynchronous and active-low.
- `WRITEENABLE` input, 1 bit: write strobe.
- `WRITEREG` input, AW bits: write address (AW = clog2(NUM_REGS)).
- `WRITEDATA` input, DATA_WIDTH bits: write data.
- `READREG1` input, AW bits: read address, port 1.
- `READREG2` input, AW bits: read address, port 2.
- `RESERVE` input, 1 bit: mark `RESERVEREG` busy.
- `RESERVEREG` input, AW bits: register to reserve.
- `REGOUT1` output, DATA_WIDTH bits: read data, port 1.
- `REGOUT2` output, DATA_WIDTH bits: read data, port 2.
- `BUSY1` output, 1 bit: register addressed by `READREG1` is busy.
- `BUSY2` output, 1 bit: register addressed by `READREG2` is busy.

## Operation
- **Reset.** `RESET` low clears all registers to 0 and all busy bits, immediately and without waiting for a clock edge.
  - While `RESET` is low, `REGOUT1/2` = 0 and `BUSY1/2` = 0 irrespective of bypass.
  - Writes and reservations are ignored while `RESET` is low.
- **Write.** On a rising `CLK` with `WRITEENABLE` = 1, `regs[WRITEREG] <= WRITEDATA` and the register's busy bit is cleared.
- **Reserve.** On a rising `CLK` with `RESERVE` = 1, `busy[RESERVEREG] <= 1`.
- **Simultaneous write and reserve to the same register.** The data is written and the busy bit ends set; the new reservation wins.
- **Read.** Combinational: `REGOUT1 = regs[READREG1]`.
  - With `BYPASS` = 1, `WRITEENABLE` = 1 and `WRITEREG == READREG1`, `REGOUT1 = WRITEDATA` instead. Port 2 behaves identically.
- **Busy flags.** `BUSY1 = busy[READREG1]`, with no bypass on busy.
  - A write in progress does not clear `BUSY1` until the clock edge.
- **Zero register.** With `ZERO_REG` = 1:
  - writes and reservations addressing register 0 are dropped;
  - reads of register 0 return 0 and are not bypassed;
  - `BUSY` for register 0 is always 0.
- **Out of range.** Addresses ≥ `NUM_REGS`:
  - writes and reservations are dropped;
  - reads return 0 with `BUSY` = 0.
- Both read ports may address the same register or the write register with no restriction.

## Timing
- Write latency: data is visible on a non-bypassed read immediately after the rising edge, with no added delay.
- Read latency: 0 cycles (combinational from address, state and, under bypass, the write inputs).
- Reserve to `BUSY` high: after the next rising edge.
- Write to `BUSY` low: after the rising edge that performs the write.
- `RESET` assertion mid-cycle discards a write pending for the next edge.
- Deassertion is synchronised externally; the first edge after deassertion performs normal operation.
- No `#` delays in RTL. Benches sample outputs 1 time unit after the edge.

## Structure
- Package `regfile_pkg` holds:
  - the `clog2`-based address width function;
  - default constants `RF_DATA_WIDTH` = 8 and `RF_NUM_REGS` = 8;
  - the localparam for an all-zero data word.
- Sub-module `reg_scoreboard`:
  - contents: the `NUM_REGS` busy-bit vector, set/clear priority, and two read-out muxes;
  - parameters: `NUM_REGS` and `ZERO_REG`;
  - ports: `CLK`, `RESET`, set/clear strobes and addresses, two query addresses, two busy outputs.
- Top level holds the storage array, the write logic, the read muxes with bypass, and the range/zero masking.

## Test plan
- **Reset.** Write 95 to r2, then pulse `RESET` low mid-cycle → `REGOUT1` (`READREG1` = 2) reads 0 immediately, before any clock edge.
- **Bypass.** With `BYPASS` = 1, `WRITEENABLE` = 1, `WRITEREG` = 1, `WRITEDATA` = 28 and `READREG1` = 1 → `REGOUT1` = 28 before the edge; after the edge with `WRITEENABLE` = 0, still 28.
  - Repeat with `BYPASS` = 0 → old value 0 before the edge, 28 after.
- **Scoreboard.** `RESERVE` r4, then `READREG2` = 4 → `BUSY2` = 1 for 3 cycles; write 15 to r4 → `BUSY2` = 0 and `REGOUT2` = 15 after the edge.
- **Reserve/write collision.** Same-edge write 6 and reserve, both to r4 → r4 = 6 and `BUSY2` = 1.
- **Zero register.** With `ZERO_REG` = 1, write 50 to r0 with `READREG1` = 0 → `REGOUT1` = 0 before and after the edge; reserving r0 leaves `BUSY1` = 0.
- **Range and width.** With `NUM_REGS` = 6 and `DATA_WIDTH` = 16:
  - write 16'hBEEF to r5 → reads back 16'hBEEF;
  - write to address 7 → dropped; `READREG1` = 7 returns 0, and r0–r5 are unchanged.
